// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - multi-port register file with per-register busy scoreboard
module register_file_sb #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 5,
  parameter int NumReadPorts = 2,
  parameter int ZeroReg      = 1,
  parameter int Bypass       = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReadPorts-1:0]           rd_req_i,
  input  logic [NumReadPorts*AddrWidth-1:0] rd_addr_i,
  output logic [NumReadPorts-1:0]           rd_gnt_o,
  output logic [NumReadPorts-1:0]           rd_valid_o,
  output logic [NumReadPorts*DataWidth-1:0] rd_data_o,
  input  logic                              lock_req_i,
  input  logic [AddrWidth-1:0]              lock_addr_i,
  output logic                              lock_gnt_o,
  input  logic                              wr_req_i,
  input  logic [AddrWidth-1:0]              wr_addr_i,
  input  logic                              wr_sel_i,
  input  logic [DataWidth-1:0]              wr_alu_data_i,
  input  logic [DataWidth-1:0]              wr_lsu_data_i,
  output logic [2**AddrWidth-1:0]           busy_o,
  output logic                              err_o
);

  localparam int NumWords = 2**AddrWidth;

  logic [DataWidth-1:0] mem [NumWords];
  logic [NumWords-1:0]  busy;
  logic [DataWidth-1:0] wdata;
  logic                 wr_zero;
  logic                 wr_legal;
  logic                 lock_zero;
  logic                 lock_bypass;
  logic [AddrWidth-1:0] rd_addr [NumReadPorts];
  logic [DataWidth-1:0] rd_next [NumReadPorts];

  assign wdata    = wr_sel_i ? wr_alu_data_i : wr_lsu_data_i;
  assign wr_zero  = (ZeroReg != 0) && (wr_addr_i == '0);
  assign wr_legal = wr_req_i && busy[wr_addr_i] && !wr_zero;
  assign busy_o   = busy;

  // A write completing this cycle releases its register early when bypass is enabled.
  assign lock_zero   = (ZeroReg != 0) && (lock_addr_i == '0);
  assign lock_bypass = (Bypass != 0) && wr_req_i && (wr_addr_i == lock_addr_i);
  assign lock_gnt_o  = lock_req_i && (!busy[lock_addr_i] || lock_bypass);

  always_comb begin
    for (int p = 0; p < NumReadPorts; p++) begin
      rd_addr[p]  = rd_addr_i[p*AddrWidth +: AddrWidth];
      rd_gnt_o[p] = rd_req_i[p] &&
                    (!busy[rd_addr[p]] ||
                     ((Bypass != 0) && wr_req_i && (wr_addr_i == rd_addr[p])));
      if ((ZeroReg != 0) && (rd_addr[p] == '0)) begin
        rd_next[p] = '0;
      end else if (wr_legal && (wr_addr_i == rd_addr[p])) begin
        rd_next[p] = wdata;
      end else begin
        rd_next[p] = mem[rd_addr[p]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWords; i++) begin
        mem[i] <= '0;
      end
      busy       <= '0;
      rd_valid_o <= '0;
      rd_data_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      err_o <= wr_req_i && !busy[wr_addr_i] && !wr_zero;
      if (wr_legal) begin
        mem[wr_addr_i]  <= wdata;
        busy[wr_addr_i] <= 1'b0;
      end
      // Placed after the write so a new reservation wins over the release.
      if (lock_gnt_o && !lock_zero) begin
        busy[lock_addr_i] <= 1'b1;
      end
      for (int p = 0; p < NumReadPorts; p++) begin
        rd_valid_o[p] <= rd_gnt_o[p];
        if (rd_gnt_o[p]) begin
          rd_data_o[p*DataWidth +: DataWidth] <= rd_next[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - scoreboard bench for register_file_sb (bypass and no-bypass instances)
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_req, rd_gnt, rd_valid;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        lock_req, lock_gnt, wr_req, wr_sel, err;
  logic [4:0]  lock_addr, wr_addr;
  logic [31:0] alu_data, lsu_data, busy;

  logic [1:0]  nb_rd_req, nb_rd_gnt, nb_rd_valid;
  logic [9:0]  nb_rd_addr;
  logic [63:0] nb_rd_data;
  logic        nb_lock_req, nb_lock_gnt, nb_wr_req, nb_err;
  logic [4:0]  nb_lock_addr, nb_wr_addr;
  logic [31:0] nb_busy;

  int n_chk = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;
  logic [31:0] exp_q [3][$];

  always #5 clk = ~clk;

  register_file_sb dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .lock_req_i(lock_req), .lock_addr_i(lock_addr), .lock_gnt_o(lock_gnt),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_sel_i(wr_sel),
    .wr_alu_data_i(alu_data), .wr_lsu_data_i(lsu_data),
    .busy_o(busy), .err_o(err)
  );

  register_file_sb #(.Bypass(0)) dut_nb (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(nb_rd_req), .rd_addr_i(nb_rd_addr), .rd_gnt_o(nb_rd_gnt),
    .rd_valid_o(nb_rd_valid), .rd_data_o(nb_rd_data),
    .lock_req_i(nb_lock_req), .lock_addr_i(nb_lock_addr), .lock_gnt_o(nb_lock_gnt),
    .wr_req_i(nb_wr_req), .wr_addr_i(nb_wr_addr), .wr_sel_i(wr_sel),
    .wr_alu_data_i(alu_data), .wr_lsu_data_i(lsu_data),
    .busy_o(nb_busy), .err_o(nb_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_req = '0; lock_req = 1'b0; wr_req = 1'b0;
    nb_rd_req = '0; nb_lock_req = 1'b0; nb_wr_req = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Port 2 stands for port 0 of the no-bypass instance.
  task automatic exp_rd(input int p, input logic g, input logic [31:0] d);
    logic got;
    got = (p == 2) ? nb_rd_gnt[0] : rd_gnt[p];
    chk($sformatf("rd_gnt p%0d", p), {31'd0, got}, {31'd0, g});
    if (g) exp_q[p].push_back(d);
  endtask

  always begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      for (int p = 0; p < 3; p++) begin
        logic        v;
        logic [31:0] d;
        v = (p == 2) ? nb_rd_valid[0] : rd_valid[p];
        d = (p == 2) ? nb_rd_data[31:0] : rd_data[p*32 +: 32];
        chk($sformatf("rd_valid p%0d", p), {31'd0, v}, {31'd0, exp_q[p].size() > 0});
        if (exp_q[p].size() > 0) chk($sformatf("rd_data p%0d", p), d, exp_q[p].pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    rd_req = '0; rd_addr = '0; lock_req = 1'b0; lock_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_sel = 1'b0; alu_data = '0; lsu_data = '0;
    nb_rd_req = '0; nb_rd_addr = '0; nb_lock_req = 1'b0; nb_lock_addr = '0;
    nb_wr_req = 1'b0; nb_wr_addr = '0;
    repeat (3) @(posedge clk);
    cyc(); mon_en = 1'b1; mid();
    chk("reset busy", busy, 32'h0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset nb busy", nb_busy, 32'h0);

    // T1: both ports read x5 after reset
    cyc(); rd_req = 2'b11; rd_addr = {5'd5, 5'd5}; mid();
    exp_rd(0, 1'b1, 32'h0); exp_rd(1, 1'b1, 32'h0);
    chk("t1 busy", busy, 32'h0);

    // T2: lock x5, ALU writeback, read back
    cyc(); lock_req = 1'b1; lock_addr = 5'd5; mid();
    chk("t2 lock_gnt", {31'd0, lock_gnt}, 32'd1);
    cyc(); wr_req = 1'b1; wr_addr = 5'd5; wr_sel = 1'b1;
    alu_data = 32'hDEADBEEF; lsu_data = 32'h55; mid();
    chk("t2 busy5 set", {31'd0, busy[5]}, 32'd1);
    cyc(); rd_req = 2'b10; rd_addr = {5'd5, 5'd0}; mid();
    chk("t2 busy5 clear", {31'd0, busy[5]}, 32'd0);
    chk("t2 err", {31'd0, err}, 32'd0);
    exp_rd(1, 1'b1, 32'hDEADBEEF);

    // T3: stalled read of x7 released by bypassed LSU writeback
    cyc(); lock_req = 1'b1; lock_addr = 5'd7; mid();
    chk("t3 lock_gnt", {31'd0, lock_gnt}, 32'd1);
    repeat (3) begin
      cyc(); rd_req = 2'b01; rd_addr = {5'd0, 5'd7}; mid();
      exp_rd(0, 1'b0, 32'h0);
    end
    cyc(); rd_req = 2'b01; rd_addr = {5'd0, 5'd7};
    wr_req = 1'b1; wr_addr = 5'd7; wr_sel = 1'b0; alu_data = 32'hFFFF; lsu_data = 32'h1234; mid();
    exp_rd(0, 1'b1, 32'h1234);
    cyc(); mid();
    chk("t3 busy7 clear", {31'd0, busy[7]}, 32'd0);

    // T4: same scenario without bypass
    cyc(); nb_lock_req = 1'b1; nb_lock_addr = 5'd7; mid();
    chk("t4 lock_gnt", {31'd0, nb_lock_gnt}, 32'd1);
    repeat (2) begin
      cyc(); nb_rd_req = 2'b01; nb_rd_addr = {5'd0, 5'd7}; mid();
      exp_rd(2, 1'b0, 32'h0);
    end
    cyc(); nb_rd_req = 2'b01; nb_rd_addr = {5'd0, 5'd7};
    nb_wr_req = 1'b1; nb_wr_addr = 5'd7; wr_sel = 1'b0; lsu_data = 32'h1234;
    nb_lock_req = 1'b1; nb_lock_addr = 5'd7; mid();
    exp_rd(2, 1'b0, 32'h0);
    chk("t4 lock in wb", {31'd0, nb_lock_gnt}, 32'd0);
    cyc(); nb_rd_req = 2'b01; nb_rd_addr = {5'd0, 5'd7}; mid();
    exp_rd(2, 1'b1, 32'h1234);

    // T5: illegal write to x9, lock/write of x0
    cyc(); wr_req = 1'b1; wr_addr = 5'd9; wr_sel = 1'b1; alu_data = 32'hAAAA; mid();
    chk("t5 err early", {31'd0, err}, 32'd0);
    cyc(); rd_req = 2'b01; rd_addr = {5'd0, 5'd9}; mid();
    chk("t5 err pulse", {31'd0, err}, 32'd1);
    exp_rd(0, 1'b1, 32'h0);
    cyc(); lock_req = 1'b1; lock_addr = 5'd0; mid();
    chk("t5 err drop", {31'd0, err}, 32'd0);
    chk("t5 lock x0", {31'd0, lock_gnt}, 32'd1);
    cyc(); wr_req = 1'b1; wr_addr = 5'd0; alu_data = 32'h77;
    rd_req = 2'b10; rd_addr = {5'd0, 5'd0}; mid();
    chk("t5 busy0", {31'd0, busy[0]}, 32'd0);
    exp_rd(1, 1'b1, 32'h0);
    cyc(); rd_req = 2'b01; rd_addr = {5'd0, 5'd0}; mid();
    chk("t5 err x0", {31'd0, err}, 32'd0);
    exp_rd(0, 1'b1, 32'h0);

    // T6: lock overrides same-cycle release, read/lock race, reset mid-read
    cyc(); lock_req = 1'b1; lock_addr = 5'd3; mid();
    chk("t6 lock x3", {31'd0, lock_gnt}, 32'd1);
    cyc(); lock_req = 1'b1; lock_addr = 5'd3;
    wr_req = 1'b1; wr_addr = 5'd3; wr_sel = 1'b1; alu_data = 32'h3333; mid();
    chk("t6 relock gnt", {31'd0, lock_gnt}, 32'd1);
    cyc(); rd_req = 2'b01; rd_addr = {5'd0, 5'd3}; mid();
    chk("t6 busy3", {31'd0, busy[3]}, 32'd1);
    chk("t6 err", {31'd0, err}, 32'd0);
    exp_rd(0, 1'b0, 32'h0);
    cyc(); rd_req = 2'b10; rd_addr = {5'd5, 5'd0}; lock_req = 1'b1; lock_addr = 5'd5; mid();
    exp_rd(1, 1'b1, 32'hDEADBEEF);
    chk("t6 lock x5", {31'd0, lock_gnt}, 32'd1);
    cyc(); mid();
    chk("t6 busy5", {31'd0, busy[5]}, 32'd1);
    cyc(); rst = 1'b1; rd_req = 2'b11; rd_addr = {5'd0, 5'd9}; mid();
    cyc(); mid();
    chk("t6 reset busy", busy, 32'h0);
    chk("t6 reset nb busy", nb_busy, 32'h0);
    chk("t6 reset err", {31'd0, err}, 32'd0);
    cyc(); rd_req = 2'b01; rd_addr = {5'd0, 5'd5}; mid();
    exp_rd(0, 1'b1, 32'h0);
    cyc(); cyc(); mid();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
